axi_burst_ram: RTL
==================

Name: axi_burst_ram

Overview:
- Parametrised AXI3 slave memory, successor to the fixed 4-beat on-chip ROM/RAM model used on the core's instruction and data buses.
- Honours AWLEN/ARLEN (1–16 beats), FIXED/INCR/WRAP bursts, WSTRB byte enables and ID echo.
- Returns SLVERR for out-of-range or malformed requests.
- Write and read channels are independent, so one write burst and one read burst can be in flight at the same time.

Parameters:
- WIDTH_ID, 2, AXI ID width.
- WIDTH_DA, 32, data width in bits; power of two, ≥ 32.
- WIDTH_AD, 32, byte address width.
- DEPTH_LOG2, 8, log2 of memory depth in words (256 words at default).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWID / AWADDR / AWLEN / AWSIZE / AWBURST  in  WIDTH_ID / WIDTH_AD / 4 / 3 / 2  write address channel.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA / WSTRB / WLAST / WVALID  in  WIDTH_DA / WIDTH_DA/8 / 1 / 1; S_AXI_WREADY out 1.
- S_AXI_BID / BRESP / BVALID  out  WIDTH_ID / 2 / 1; S_AXI_BREADY in 1.
- S_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST / ARVALID  in  as AW; S_AXI_ARREADY out 1.
- S_AXI_RID / RDATA / RRESP / RLAST / RVALID  out  WIDTH_ID / WIDTH_DA / 2 / 1 / 1; S_AXI_RREADY in 1.

Behaviour:
- Reset (async assert, sync release):
  - AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0.
  - BRESP=0, RRESP=0, BID=0, RID=0, RDATA=0.
  - Both FSMs go to idle. Memory contents are not reset.
  - Reset mid-burst aborts the burst; no further beats, no B response.
- Addressing:
  - B = log2(WIDTH_DA/8).
  - Word index = addr[DEPTH_LOG2+B-1:B].
  - Beat is out of range if any addr bit above DEPTH_LOG2+B-1 is set.
  - AxSIZE is ignored; every beat is full width and the address steps by WIDTH_DA/8.
- Burst types:
  - FIXED: address constant for all beats.
  - INCR: address += WIDTH_DA/8 per beat, full WIDTH_AD arithmetic, so a beat may leave the range.
  - WRAP: legal only for LEN ∈ {1,3,7,15}. Word index wraps inside an aligned block of LEN+1 words.
  - WRAP with any other LEN is executed as INCR and flagged SLVERR.
  - BURST=2'b11 is executed as INCR and flagged SLVERR.
- Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, ADDR, LEN, BURST; clear beat counter and error flag; AWREADY=0, WREADY=1.
  - W_DATA: one beat per WVALID&WREADY. Bytes with WSTRB=1 are written; in-range beats only. Out-of-range beats write nothing and set the error flag.
  - WLAST must be 1 exactly on beat LEN. A mismatch sets the error flag.
  - The burst ends on beat count = LEN regardless of WLAST. The cycle after the last beat: WREADY=0, BVALID=1, BID=latched ID, BRESP=2'b10 if error else 2'b00.
  - W_RESP: hold BVALID, BID, BRESP until BREADY. Then BVALID=0, AWREADY=1.
- Read FSM, R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch request and deassert ARREADY.
  - First RVALID is on the next cycle (1-cycle latency) with RDATA = mem[first index].
  - Each RVALID&RREADY advances to the next beat in the following cycle. RVALID stays high through the burst at one beat per cycle when RREADY is held.
  - RDATA, RRESP, RLAST are stable while RVALID&!RREADY.
  - RLAST=1 only on beat LEN. RID = latched ID.
  - Out-of-range beat: RDATA=0, RRESP=2'b10. Malformed burst: RRESP=2'b10 on every beat.
  - After the last handshake: RVALID=0, RLAST=0, ARREADY=1 on the next cycle.
- Concurrency:
  - A read and a write to the same word on the same edge: the read returns the old data (read-first).
  - A read that has not yet issued a beat sees writes from earlier cycles.
- Memory: plain reg array of 2^DEPTH_LOG2 × WIDTH_DA with a byte-lane write loop. No initialisation logic beyond optional $readmemh in simulation.

Test Plan:
- INCR write, AWADDR=0x10, AWLEN=3, data 0xA0..A3, WSTRB=0xF; then INCR read of the same → BRESP=0; words 4–7 written; RDATA A0,A1,A2,A3 with RLAST on 4th beat only; RRESP=0.
- WRAP read, ARADDR=0x18, ARLEN=3, memory words 4–7 = A0..A3 → word order 6,7,4,5 (A2,A3,A0,A1); RLAST on beat 4.
- Write to word 2 = 0x11223344, then WSTRB=0x5 with data 0xFFFFFFFF → word 2 = 0x11FF33FF.
- INCR write AWADDR=0x3F8, AWLEN=3 (DEPTH_LOG2=8) → words 254–255 written; beats 3–4 not written; BRESP=2'b10. Matching read: beats 3–4 RDATA=0, RRESP=2'b10.
- RREADY toggled 1,0,0,1,… during a 16-beat read → no beat lost or duplicated; outputs stable while stalled; RID echoes ARID=2.
- Assert S_AXI_ARESET mid write burst at beat 2 → all outputs reset immediately; no BVALID afterwards; a fresh burst completes normally.

Source files
------------

// File: rtl/axi_burst_ram.sv
// AXI3 slave RAM with 1-16 beat FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR on bad beats.
// Latency: one beat per cycle on W and R; first RVALID one cycle after the AR handshake.
// Backpressure: WREADY/AWREADY/ARREADY drop while a burst is busy; B and R outputs hold until BREADY/RREADY.
module axi_burst_ram #(
   parameter int WIDTH_ID   = 2,
   parameter int WIDTH_DA   = 32,
   parameter int WIDTH_AD   = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESET,
   // write address channel
   input  logic [WIDTH_ID-1:0]     S_AXI_AWID,
   input  logic [WIDTH_AD-1:0]     S_AXI_AWADDR,
   input  logic [3:0]              S_AXI_AWLEN,
   input  logic [2:0]              S_AXI_AWSIZE,
   input  logic [1:0]              S_AXI_AWBURST,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   // write data channel
   input  logic [WIDTH_DA-1:0]     S_AXI_WDATA,
   input  logic [WIDTH_DA/8-1:0]   S_AXI_WSTRB,
   input  logic                    S_AXI_WLAST,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   // write response channel
   output logic [WIDTH_ID-1:0]     S_AXI_BID,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   // read address channel
   input  logic [WIDTH_ID-1:0]     S_AXI_ARID,
   input  logic [WIDTH_AD-1:0]     S_AXI_ARADDR,
   input  logic [3:0]              S_AXI_ARLEN,
   input  logic [2:0]              S_AXI_ARSIZE,
   input  logic [1:0]              S_AXI_ARBURST,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   // read data channel
   output logic [WIDTH_ID-1:0]     S_AXI_RID,
   output logic [WIDTH_DA-1:0]     S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RLAST,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY
);

   localparam int NB    = WIDTH_DA / 8;
   localparam int B     = $clog2(NB);
   localparam int WA    = WIDTH_AD - B;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Any set bit above the memory's byte-address range makes the beat invalid.
   function automatic logic out_of_range(input logic [WIDTH_AD-1:0] a);
      return |a[WIDTH_AD-1:DEPTH_LOG2+B];
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [WIDTH_AD-1:0] a);
      return a[DEPTH_LOG2+B-1:B];
   endfunction

   // WRAP only makes sense for power-of-two beat counts; reserved burst type is also rejected.
   function automatic logic malformed(input logic [1:0] burst, input logic [3:0] len);
      return (burst == 2'b11) ||
             ((burst == BURST_WRAP) &&
              !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)));
   endfunction

   // Malformed bursts still run to completion, walking addresses like INCR.
   function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [3:0] len);
      return malformed(burst, len) ? BURST_INCR : burst;
   endfunction

   // Address of the following beat; WRAP keeps the word index inside an aligned LEN+1 block.
   function automatic logic [WIDTH_AD-1:0] next_addr(input logic [WIDTH_AD-1:0] a,
                                                     input logic [1:0]          burst,
                                                     input logic [3:0]          len);
      logic [WA-1:0] w;
      logic [WA-1:0] m;
      w = a[WIDTH_AD-1:B];
      m = WA'(len);
      case (burst)
         BURST_FIXED: return a;
         BURST_WRAP: begin
            w = (w & ~m) | ((w + WA'(1)) & m);
            return {w, a[B-1:0]};
         end
         default: return a + WIDTH_AD'(NB);
      endcase
   endfunction

   // Transfer size is not honoured: every beat is full width.
   logic unused_size;
   assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

   logic [WIDTH_DA-1:0] mem [DEPTH];

   // ------------------------------------------------------------------ write side
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   w_state_t            w_state;
   logic [WIDTH_ID-1:0] w_id;
   logic [WIDTH_AD-1:0] w_addr;
   logic [3:0]          w_len;
   logic [3:0]          w_cnt;
   logic [1:0]          w_burst;
   logic                w_err;

   logic w_beat;
   logic w_last_beat;
   logic w_beat_oor;
   logic w_beat_err;
   logic mem_we;

   assign w_beat      = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
   assign w_last_beat = (w_cnt == w_len);
   assign w_beat_oor  = out_of_range(w_addr);
   assign w_beat_err  = w_beat_oor || (S_AXI_WLAST != w_last_beat);
   assign mem_we      = w_beat && !w_beat_oor;

   // Write FSM: accept AW, take LEN+1 beats counted locally, then hold B until BREADY.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         w_state       <= W_IDLE;
         S_AXI_AWREADY <= 1'b1;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         S_AXI_BID     <= '0;
         w_id          <= '0;
         w_addr        <= '0;
         w_len         <= '0;
         w_cnt         <= '0;
         w_burst       <= BURST_FIXED;
         w_err         <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                  w_id          <= S_AXI_AWID;
                  w_addr        <= S_AXI_AWADDR;
                  w_len         <= S_AXI_AWLEN;
                  w_burst       <= eff_burst(S_AXI_AWBURST, S_AXI_AWLEN);
                  w_err         <= malformed(S_AXI_AWBURST, S_AXI_AWLEN);
                  w_cnt         <= '0;
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b1;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_beat) begin
                  if (w_last_beat) begin
                     // Burst length comes from AWLEN; a wrong WLAST only affects BRESP.
                     S_AXI_WREADY <= 1'b0;
                     S_AXI_BVALID <= 1'b1;
                     S_AXI_BID    <= w_id;
                     S_AXI_BRESP  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     w_state      <= W_RESP;
                  end else begin
                     w_cnt  <= w_cnt + 4'd1;
                     w_addr <= next_addr(w_addr, w_burst, w_len);
                     w_err  <= w_err || w_beat_err;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID  <= 1'b0;
                  S_AXI_AWREADY <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Byte-lane write of in-range beats; contents survive reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (S_AXI_WSTRB[i]) begin
               mem[word_idx(w_addr)][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------ read side
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   r_state_t            r_state;
   logic [WIDTH_AD-1:0] r_addr;
   logic [3:0]          r_len;
   logic [3:0]          r_cnt;
   logic [1:0]          r_burst;
   logic                r_bad;

   // Address of the beat about to be loaded: the request itself in idle, else the successor.
   logic [WIDTH_AD-1:0] r_fetch_addr;
   logic                r_fetch_oor;
   logic [WIDTH_DA-1:0] r_fetch_dat;

   assign r_fetch_addr = (r_state == R_IDLE) ? S_AXI_ARADDR : next_addr(r_addr, r_burst, r_len);
   assign r_fetch_oor  = out_of_range(r_fetch_addr);
   assign r_fetch_dat  = r_fetch_oor ? '0 : mem[word_idx(r_fetch_addr)];

   // Read FSM: registered beat outputs, reloaded only on a handshake so they hold while stalled.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b1;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RLAST   <= 1'b0;
         S_AXI_RRESP   <= RESP_OKAY;
         S_AXI_RID     <= '0;
         S_AXI_RDATA   <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_cnt         <= '0;
         r_burst       <= BURST_FIXED;
         r_bad         <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                  r_addr        <= S_AXI_ARADDR;
                  r_len         <= S_AXI_ARLEN;
                  r_burst       <= eff_burst(S_AXI_ARBURST, S_AXI_ARLEN);
                  r_bad         <= malformed(S_AXI_ARBURST, S_AXI_ARLEN);
                  r_cnt         <= '0;
                  S_AXI_RID     <= S_AXI_ARID;
                  S_AXI_RDATA   <= r_fetch_dat;
                  S_AXI_RRESP   <= (malformed(S_AXI_ARBURST, S_AXI_ARLEN) || r_fetch_oor) ?
                                   RESP_SLVERR : RESP_OKAY;
                  S_AXI_RLAST   <= (S_AXI_ARLEN == 4'd0);
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_ARREADY <= 1'b0;
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (S_AXI_RVALID && S_AXI_RREADY) begin
                  if (S_AXI_RLAST) begin
                     S_AXI_RVALID  <= 1'b0;
                     S_AXI_RLAST   <= 1'b0;
                     S_AXI_ARREADY <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     r_addr      <= r_fetch_addr;
                     r_cnt       <= r_cnt + 4'd1;
                     S_AXI_RDATA <= r_fetch_dat;
                     S_AXI_RRESP <= (r_bad || r_fetch_oor) ? RESP_SLVERR : RESP_OKAY;
                     S_AXI_RLAST <= ((r_cnt + 4'd1) == r_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule
